bus_access_controller: RTL

- CPU-side bus master FSM between the CPU core's memory-access request and the external ECO32-style bus (enable / write / size / wait).
- Latches one request, checks alignment, and drives a single bus cycle until the slave releases wait.
- Consumes the bus timeout counter: drives its clear input and watches its alarm output.
- Reports one of three completions to the CPU: ready, misaligned error, or timeout error.

---
 rtl/bus_access_controller_if.sv | 49 ++++
 rtl/bus_access_controller.sv | 111 +++++++++++
 2 files changed

// File: rtl/bus_access_controller_if.sv
// CPU-side request/response and ECO32-style bus signals of the
// bus access controller, plus the timeout counter hookup.
interface bus_access_controller_if #(
   parameter int ADDRESS_WIDTH = 32
);
   logic                     cpu_request;
   logic                     cpu_write;
   logic [1:0]               cpu_size;
   logic [ADDRESS_WIDTH-1:0] cpu_address;
   logic [31:0]              cpu_write_data;
   logic [31:0]              cpu_read_data;
   logic                     cpu_ready;
   logic                     cpu_error;
   logic [1:0]               cpu_error_cause;
   logic [ADDRESS_WIDTH-1:0] cpu_error_address;
   logic                     bus_enable;
   logic                     bus_write;
   logic [1:0]               bus_size;
   logic [ADDRESS_WIDTH-1:0] bus_address;
   logic [31:0]              bus_write_data;
   logic [31:0]              bus_read_data;
   logic                     bus_wait;
   logic                     timeout_clear;
   logic                     timeout_alarm;

   modport master (
      input  cpu_request, cpu_write, cpu_size,
      input  cpu_address, cpu_write_data,
      output cpu_read_data, cpu_ready, cpu_error,
      output cpu_error_cause, cpu_error_address,
      output bus_enable, bus_write, bus_size,
      output bus_address, bus_write_data,
      input  bus_read_data, bus_wait,
      output timeout_clear,
      input  timeout_alarm
   );

   modport slave (
      output cpu_request, cpu_write, cpu_size,
      output cpu_address, cpu_write_data,
      input  cpu_read_data, cpu_ready, cpu_error,
      input  cpu_error_cause, cpu_error_address,
      input  bus_enable, bus_write, bus_size,
      input  bus_address, bus_write_data,
      output bus_read_data, bus_wait,
      input  timeout_clear,
      output timeout_alarm
   );
endinterface

// File: rtl/bus_access_controller.sv
// CPU bus master: latches one request, checks alignment, runs a
// single bus cycle and reports ready, misaligned or timeout.
module bus_access_controller #(
   parameter int ADDRESS_WIDTH = 32
) (
   input logic                     clock,
   input logic                     reset_n,
   bus_access_controller_if.master bif
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE,
      ERROR
   } state_t;

   state_t                   state_q, state_d;
   logic                     write_q, write_d;
   logic [1:0]               size_q, size_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [31:0]              rdata_q, rdata_d;
   logic [1:0]               cause_q, cause_d;
   logic                     misaligned;

   // size 11 decodes as a word
   always_comb begin
      misaligned = 1'b0;
      unique case (1'b1)
         (bif.cpu_size == 2'b00):
            misaligned = 1'b0;
         (bif.cpu_size == 2'b01):
            misaligned = bif.cpu_address[0];
         default:
            misaligned = |bif.cpu_address[1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            if (bif.cpu_request) begin
               write_d = bif.cpu_write;
               size_d  = bif.cpu_size;
               addr_d  = bif.cpu_address;
               wdata_d = bif.cpu_write_data;
               if (misaligned) begin
                  state_d = ERROR;
                  cause_d = 2'b01;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // completion beats a same-cycle alarm
            if (!bif.bus_wait) begin
               if (!write_q) rdata_d = bif.bus_read_data;
               state_d = DONE;
            end else if (bif.timeout_alarm) begin
               state_d = ERROR;
               cause_d = 2'b10;
            end
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cause_q <= cause_d;
      end
   end

   assign bif.bus_enable        = (state_q == ACCESS);
   assign bif.bus_write         = (state_q == ACCESS) & write_q;
   assign bif.bus_size          = size_q;
   assign bif.bus_address       = addr_q;
   assign bif.bus_write_data    = wdata_q;
   assign bif.timeout_clear     = (state_q != ACCESS);
   assign bif.cpu_ready         = (state_q == DONE);
   assign bif.cpu_error         = (state_q == ERROR);
   assign bif.cpu_error_cause   = cause_q;
   assign bif.cpu_error_address = addr_q;
   assign bif.cpu_read_data     = rdata_q;

endmodule
